hdmi_cut_cfg_ctrl: RTL

//  Owns the video-cut configuration (Cut_Width, Cut_High, sel_bit) that feeds the HDMI transmitter.

---
 rtl/hdmi_cut_cfg_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_cut_cfg_ctrl.sv
// hdmi_cut_cfg_ctrl
//   Holds the video-cut configuration (cut width, cut height, pixel bit-slice
//   select) that drives the HDMI transmitter. Two requesters update a staging
//   copy: a host port with absolute values and a key port with step commands.
//   Each request is clamped into the legal range. The staging copy reaches the
//   outputs only at a rising edge of vertical sync, so the window never changes
//   mid-frame.
//
// Ports
//   Pixl_CLK      pixel clock (sole clock)
//   Rst_n         synchronous active-low reset
//   I_VGA_Sync    TX vertical sync, active-high
//   I_Host_Req    host request, held until O_Host_Ack
//   I_Host_Width  requested width (12b)
//   I_Host_High   requested height (12b)
//   I_Host_Sel    requested sel_bit (4b)
//   O_Host_Ack    one-cycle accept pulse to host
//   I_Key_Req     key request, held until O_Key_Ack
//   I_Key_Cmd     00 grow, 01 shrink, 10 sel up, 11 sel down
//   O_Key_Ack     one-cycle accept pulse to key source
//   Cut_Width     committed width
//   Cut_High      committed height
//   sel_bit       committed bit-slice select
//   O_Cfg_Pending staging awaiting commit
//   O_Commit      one-cycle pulse on the first cycle of new outputs
module hdmi_cut_cfg_ctrl #(
  parameter int H_ActiveSize = 1280,
  parameter int V_ActiveSize = 1024,
  parameter int MIN_W        = 64,
  parameter int MIN_H        = 64,
  parameter int STEP         = 32,
  parameter int SEL_MAX      = 8
) (
  input  logic        Pixl_CLK,
  input  logic        Rst_n,
  input  logic        I_VGA_Sync,
  input  logic        I_Host_Req,
  input  logic [11:0] I_Host_Width,
  input  logic [11:0] I_Host_High,
  input  logic [3:0]  I_Host_Sel,
  output logic        O_Host_Ack,
  input  logic        I_Key_Req,
  input  logic [1:0]  I_Key_Cmd,
  output logic        O_Key_Ack,
  output logic [11:0] Cut_Width,
  output logic [11:0] Cut_High,
  output logic [3:0]  sel_bit,
  output logic        O_Cfg_Pending,
  output logic        O_Commit
);

  localparam logic [11:0] W_MAX   = 12'(H_ActiveSize);
  localparam logic [11:0] H_MAX   = 12'(V_ActiveSize);
  localparam logic [11:0] W_MIN   = 12'(MIN_W);
  localparam logic [11:0] H_MIN   = 12'(MIN_H);
  localparam logic [12:0] STEP13  = 13'(STEP);
  localparam logic [3:0]  SEL_TOP = 4'(SEL_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic        vs_q, vs_d;
  logic        prio_host_q, prio_host_d;
  logic        host_ack_q, host_ack_d;
  logic        key_ack_q, key_ack_d;
  logic [11:0] lat_w_q, lat_w_d;
  logic [11:0] lat_h_q, lat_h_d;
  logic [3:0]  lat_sel_q, lat_sel_d;
  logic [1:0]  lat_cmd_q, lat_cmd_d;
  logic [11:0] stg_w_q, stg_w_d;
  logic [11:0] stg_h_q, stg_h_d;
  logic [3:0]  stg_sel_q, stg_sel_d;
  logic [11:0] cut_w_q, cut_w_d;
  logic [11:0] cut_h_q, cut_h_d;
  logic [3:0]  cut_sel_q, cut_sel_d;

  logic        vs_rise;
  logic        host_elig, key_elig;
  logic        grant_host, grant_key, any_grant;
  logic        enter_commit;
  logic [11:0] host_w_c, host_h_c;
  logic [3:0]  host_sel_c;
  logic [12:0] grow_w13, grow_h13, shr_w13, shr_h13;
  logic [11:0] key_w, key_h;
  logic [3:0]  key_sel;

  assign vs_rise = I_VGA_Sync & ~vs_q;

  // A requester is not re-accepted while its ack is showing, which spaces
  // grants on one side at least two cycles apart.
  assign host_elig  = I_Host_Req & ~host_ack_q;
  assign key_elig   = I_Key_Req & ~key_ack_q;
  assign grant_host = host_elig & (~key_elig | prio_host_q);
  assign grant_key  = key_elig & (~host_elig | ~prio_host_q);
  assign any_grant  = grant_host | grant_key;

  assign enter_commit = (state_q == ST_PEND) && vs_rise;

  // Host values are clamped when latched; min/max bounds are even, so only
  // the in-range case can carry an odd LSB.
  always_comb begin
    host_w_c = I_Host_Width;
    if (I_Host_Width < W_MIN)      host_w_c = W_MIN;
    else if (I_Host_Width > W_MAX) host_w_c = W_MAX;
    host_w_c[0] = 1'b0;

    host_h_c = I_Host_High;
    if (I_Host_High < H_MIN)      host_h_c = H_MIN;
    else if (I_Host_High > H_MAX) host_h_c = H_MAX;
    host_h_c[0] = 1'b0;

    host_sel_c = (I_Host_Sel > SEL_TOP) ? SEL_TOP : I_Host_Sel;
  end

  // Key step results against the current staging values. Shrink is done in
  // 13 bits so a borrow shows up in bit 12 instead of wrapping.
  always_comb begin
    grow_w13 = {1'b0, stg_w_q} + STEP13;
    grow_h13 = {1'b0, stg_h_q} + STEP13;
    shr_w13  = {1'b0, stg_w_q} - STEP13;
    shr_h13  = {1'b0, stg_h_q} - STEP13;
    key_w    = stg_w_q;
    key_h    = stg_h_q;
    key_sel  = stg_sel_q;
    case (lat_cmd_q)
      2'b00: begin
        key_w = (grow_w13 > {1'b0, W_MAX}) ? W_MAX : grow_w13[11:0];
        key_h = (grow_h13 > {1'b0, H_MAX}) ? H_MAX : grow_h13[11:0];
      end
      2'b01: begin
        key_w = (shr_w13[12] || (shr_w13[11:0] < W_MIN)) ? W_MIN : shr_w13[11:0];
        key_h = (shr_h13[12] || (shr_h13[11:0] < H_MIN)) ? H_MIN : shr_h13[11:0];
      end
      2'b10: key_sel = (stg_sel_q >= SEL_TOP) ? SEL_TOP : stg_sel_q + 4'd1;
      default: key_sel = (stg_sel_q == 4'd0) ? 4'd0 : stg_sel_q - 4'd1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    vs_d        = I_VGA_Sync;
    prio_host_d = prio_host_q;
    host_ack_d  = grant_host;
    key_ack_d   = grant_key;
    lat_w_d     = lat_w_q;
    lat_h_d     = lat_h_q;
    lat_sel_d   = lat_sel_q;
    lat_cmd_d   = lat_cmd_q;
    stg_w_d     = stg_w_q;
    stg_h_d     = stg_h_q;
    stg_sel_d   = stg_sel_q;
    cut_w_d     = cut_w_q;
    cut_h_d     = cut_h_q;
    cut_sel_d   = cut_sel_q;

    if (grant_host) begin
      prio_host_d = 1'b0;
      lat_w_d     = host_w_c;
      lat_h_d     = host_h_c;
      lat_sel_d   = host_sel_c;
    end
    if (grant_key) begin
      prio_host_d = 1'b1;
      lat_cmd_d   = I_Key_Cmd;
    end

    // The latched request lands in staging at the end of its ack cycle.
    if (host_ack_q) begin
      stg_w_d   = lat_w_q;
      stg_h_d   = lat_h_q;
      stg_sel_d = lat_sel_q;
    end else if (key_ack_q) begin
      stg_w_d   = key_w;
      stg_h_d   = key_h;
      stg_sel_d = key_sel;
    end

    // Loading from staging_d picks up a request whose ack is ending now, but
    // not one granted on this same edge (that one lands a cycle later).
    if (enter_commit) begin
      cut_w_d   = stg_w_d;
      cut_h_d   = stg_h_d;
      cut_sel_d = stg_sel_d;
    end

    case (state_q)
      ST_IDLE:   if (any_grant) state_d = ST_PEND;
      ST_PEND:   if (vs_rise) state_d = ST_COMMIT;
      ST_COMMIT: begin
        // An ack still showing means a request granted on the commit edge
        // has not reached the outputs yet.
        if (any_grant || host_ack_q || key_ack_q) state_d = ST_PEND;
        else                                      state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Pixl_CLK) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      vs_q        <= 1'b0;
      prio_host_q <= 1'b1;
      host_ack_q  <= 1'b0;
      key_ack_q   <= 1'b0;
      lat_w_q     <= 12'd0;
      lat_h_q     <= 12'd0;
      lat_sel_q   <= 4'd0;
      lat_cmd_q   <= 2'd0;
      stg_w_q     <= W_MAX;
      stg_h_q     <= H_MAX;
      stg_sel_q   <= SEL_TOP;
      cut_w_q     <= W_MAX;
      cut_h_q     <= H_MAX;
      cut_sel_q   <= SEL_TOP;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_d;
      prio_host_q <= prio_host_d;
      host_ack_q  <= host_ack_d;
      key_ack_q   <= key_ack_d;
      lat_w_q     <= lat_w_d;
      lat_h_q     <= lat_h_d;
      lat_sel_q   <= lat_sel_d;
      lat_cmd_q   <= lat_cmd_d;
      stg_w_q     <= stg_w_d;
      stg_h_q     <= stg_h_d;
      stg_sel_q   <= stg_sel_d;
      cut_w_q     <= cut_w_d;
      cut_h_q     <= cut_h_d;
      cut_sel_q   <= cut_sel_d;
    end
  end

  assign O_Host_Ack    = host_ack_q;
  assign O_Key_Ack     = key_ack_q;
  assign Cut_Width     = cut_w_q;
  assign Cut_High      = cut_h_q;
  assign sel_bit       = cut_sel_q;
  assign O_Cfg_Pending = (state_q == ST_PEND);
  assign O_Commit      = (state_q == ST_COMMIT);

endmodule
